// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for the shared ALU: an operation request channel
// plus a one-entry response channel, each with its own valid/ready pair.
interface alu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 10
);
  logic            valid;
  logic            ready;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            sel;
  logic [4:0]      shamt;
  logic            rvalid;
  logic            rready;
  logic [XLEN-1:0] res;

  modport master (
    output valid, op, rs1, rs2, imm, sel, shamt, rready,
    input  ready, rvalid, res
  );

  modport slave (
    input  valid, op, rs1, rs2, imm, sel, shamt, rready,
    output ready, rvalid, res
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute stage (r0)
// and the address/CSR helper (r1), each with a one-entry response slot.
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int OPW   = 10,
  parameter int FIRST = 0
) (
  input  logic            clock,
  input  logic            reset,
  alu_arbiter_if.slave    r0,
  alu_arbiter_if.slave    r1,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [XLEN-1:0] alu_imm,
  output logic            alu_sel,
  output logic [4:0]      alu_shamt,
  input  logic [XLEN-1:0] alu_res
);

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      slot_free;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic            rvalid_reg [2];
  logic [XLEN-1:0] res_reg [2];
  logic            ptr_reg;
  logic            ptr_next;

  assign req_valid = {r1.valid, r0.valid};
  assign rsp_ready = {r1.rready, r0.rready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // A full slot being drained this cycle may be refilled in the same cycle.
      assign slot_free[gi] = !rvalid_reg[gi] || rsp_ready[gi];
      assign elig[gi]      = req_valid[gi] && slot_free[gi] && !reset;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rvalid_reg[gi] <= 1'b0;
          res_reg[gi]    <= '0;
        end else if (grant[gi]) begin
          rvalid_reg[gi] <= 1'b1;
          res_reg[gi]    <= alu_res;
        end else if (rvalid_reg[gi] && rsp_ready[gi]) begin
          rvalid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    grant[0] = elig[0] && (!elig[1] || (ptr_reg == 1'b0));
    grant[1] = elig[1] && (!elig[0] || (ptr_reg == 1'b1));
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant[0]) begin
      ptr_next = 1'b1;
    end else if (grant[1]) begin
      ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_reg <= 1'(FIRST);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // With no grant the ALU sees opcode 0 and all-zero operands.
  always_comb begin
    alu_op    = '0;
    alu_rs1   = '0;
    alu_rs2   = '0;
    alu_imm   = '0;
    alu_sel   = 1'b0;
    alu_shamt = '0;
    if (grant[0]) begin
      alu_op    = r0.op;
      alu_rs1   = r0.rs1;
      alu_rs2   = r0.rs2;
      alu_imm   = r0.imm;
      alu_sel   = r0.sel;
      alu_shamt = r0.shamt;
    end else if (grant[1]) begin
      alu_op    = r1.op;
      alu_rs1   = r1.rs1;
      alu_rs2   = r1.rs2;
      alu_imm   = r1.imm;
      alu_sel   = r1.sel;
      alu_shamt = r1.shamt;
    end
  end

  assign r0.ready  = grant[0];
  assign r1.ready  = grant[1];
  assign r0.rvalid = rvalid_reg[0];
  assign r1.rvalid = rvalid_reg[1];
  assign r0.res    = res_reg[0];
  assign r1.res    = res_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with a small reference ALU on the
// alu_* side; per-cycle vectors plus a hand-written asynchronous reset sequence.
module tb_alu_arbiter;

  localparam logic [9:0] OP_ADD  = 10'b00_0000_0001;
  localparam logic [9:0] OP_SUB  = 10'b00_0000_0010;
  localparam logic [9:0] OP_SLL  = 10'b00_0000_0100;
  localparam logic [9:0] OP_SRL  = 10'b00_0000_1000;
  localparam logic [9:0] OP_SRA  = 10'b00_0001_0000;
  localparam logic [9:0] OP_SLT  = 10'b00_0010_0000;
  localparam logic [9:0] OP_SLTU = 10'b00_0100_0000;
  localparam logic [9:0] OP_AND  = 10'b00_1000_0000;
  localparam logic [9:0] OP_OR   = 10'b01_0000_0000;
  localparam logic [9:0] OP_XOR  = 10'b10_0000_0000;

  logic        clock;
  logic        reset;
  logic [9:0]  alu_op;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [31:0] alu_imm;
  logic        alu_sel;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_res;

  int checks;
  int failures;

  alu_arbiter_if #(.XLEN(32), .OPW(10)) r0_if ();
  alu_arbiter_if #(.XLEN(32), .OPW(10)) r1_if ();

  alu_arbiter #(.XLEN(32), .OPW(10), .FIRST(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .r0        (r0_if),
    .r1        (r1_if),
    .alu_op    (alu_op),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_imm   (alu_imm),
    .alu_sel   (alu_sel),
    .alu_shamt (alu_shamt),
    .alu_res   (alu_res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU: results of every selected opcode bit are ORed together.
  logic [31:0] op2;
  always_comb begin
    op2     = alu_sel ? alu_imm : alu_rs2;
    alu_res = '0;
    if (alu_op[0]) alu_res = alu_res | (alu_rs1 + op2);
    if (alu_op[1]) alu_res = alu_res | (alu_rs1 - op2);
    if (alu_op[2]) alu_res = alu_res | (alu_rs1 << alu_shamt);
    if (alu_op[3]) alu_res = alu_res | (alu_rs1 >> alu_shamt);
    if (alu_op[4]) alu_res = alu_res | 32'($signed(alu_rs1) >>> alu_shamt);
    if (alu_op[5]) alu_res = alu_res | {31'b0, $signed(alu_rs1) < $signed(op2)};
    if (alu_op[6]) alu_res = alu_res | {31'b0, alu_rs1 < op2};
    if (alu_op[7]) alu_res = alu_res | (alu_rs1 & op2);
    if (alu_op[8]) alu_res = alu_res | (alu_rs1 | op2);
    if (alu_op[9]) alu_res = alu_res | (alu_rs1 ^ op2);
  end

  typedef struct {
    logic        valid;
    logic [9:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        sel;
    logic [4:0]  shamt;
    logic        rready;
  } req_t;

  typedef struct {
    req_t        r0;
    req_t        r1;
    logic        ready0;
    logic        ready1;
    logic        rv0;
    logic [31:0] res0;
    logic        rv1;
    logic [31:0] res1;
  } vec_t;

  function automatic req_t rq(logic v, logic [9:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic sel, logic [4:0] sh, logic rr);
    req_t r;
    r.valid = v; r.op = op; r.rs1 = a; r.rs2 = b;
    r.imm = imm; r.sel = sel; r.shamt = sh; r.rready = rr;
    return r;
  endfunction

  function automatic vec_t mk(req_t a, req_t b, logic rd0, logic rd1,
                              logic v0, logic [31:0] s0, logic v1, logic [31:0] s1);
    vec_t v;
    v.r0 = a; v.r1 = b; v.ready0 = rd0; v.ready1 = rd1;
    v.rv0 = v0; v.res0 = s0; v.rv1 = v1; v.res1 = s1;
    return v;
  endfunction

  task automatic drive(req_t a, req_t b);
    r0_if.valid = a.valid; r0_if.op = a.op; r0_if.rs1 = a.rs1; r0_if.rs2 = a.rs2;
    r0_if.imm = a.imm; r0_if.sel = a.sel; r0_if.shamt = a.shamt; r0_if.rready = a.rready;
    r1_if.valid = b.valid; r1_if.op = b.op; r1_if.rs1 = b.rs1; r1_if.rs2 = b.rs2;
    r1_if.imm = b.imm; r1_if.sel = b.sel; r1_if.shamt = b.shamt; r1_if.rready = b.rready;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  vec_t vecs[13];
  req_t idle0;
  req_t idle1;
  req_t rq_add;

  initial begin
    checks   = 0;
    failures = 0;
    idle0  = rq(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    idle1  = rq(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
    rq_add = rq(1'b1, OP_ADD, 32'd2, 32'd3, '0, 1'b0, '0, 1'b0);

    vecs[0]  = mk(rq(1'b1, OP_AND, 32'hFF00, 32'h0FF0, '0, 1'b0, '0, 1'b0),
                  rq(1'b1, OP_SLL, 32'h1, '0, '0, 1'b0, 5'd4, 1'b0),
                  1'b1, 1'b0, 1'b1, 32'h0F00, 1'b0, 32'h0);
    vecs[1]  = mk(idle1, rq(1'b1, OP_SLL, 32'h1, '0, '0, 1'b0, 5'd4, 1'b0),
                  1'b0, 1'b1, 1'b0, 32'h0F00, 1'b1, 32'h10);
    vecs[2]  = mk(idle0, idle1, 1'b0, 1'b0, 1'b0, 32'h0F00, 1'b0, 32'h10);
    vecs[3]  = mk(rq(1'b1, OP_XOR, 32'hF0, 32'hFF, '0, 1'b0, '0, 1'b0), idle0,
                  1'b1, 1'b0, 1'b1, 32'h0F, 1'b0, 32'h10);
    vecs[4]  = mk(rq_add, rq(1'b1, OP_OR, 32'h1, 32'hFFFF_FFFF, 32'h8, 1'b1, '0, 1'b1),
                  1'b0, 1'b1, 1'b1, 32'h0F, 1'b1, 32'h9);
    vecs[5]  = mk(rq_add, rq(1'b1, OP_SUB, 32'd10, 32'd3, '0, 1'b0, '0, 1'b1),
                  1'b0, 1'b1, 1'b1, 32'h0F, 1'b1, 32'd7);
    vecs[6]  = mk(rq_add, rq(1'b1, OP_SRA, 32'h8000_0000, '0, '0, 1'b0, 5'd4, 1'b1),
                  1'b0, 1'b1, 1'b1, 32'h0F, 1'b1, 32'hF800_0000);
    vecs[7]  = mk(rq(1'b1, OP_ADD, 32'd2, 32'd3, '0, 1'b0, '0, 1'b1),
                  rq(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'h1, '0, 1'b0, '0, 1'b1),
                  1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 32'hF800_0000);
    vecs[8]  = mk(idle1, rq(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'h1, '0, 1'b0, '0, 1'b1),
                  1'b0, 1'b1, 1'b0, 32'd5, 1'b1, 32'h1);
    vecs[9]  = mk(rq(1'b1, 10'b0, 32'd5, 32'd6, '0, 1'b0, '0, 1'b0),
                  rq(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'h1, '0, 1'b0, '0, 1'b1),
                  1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h1);
    vecs[10] = mk(rq(1'b1, OP_SRL, 32'h8000_0000, '0, '0, 1'b0, 5'd31, 1'b1),
                  rq(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'h1, '0, 1'b0, '0, 1'b1),
                  1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    vecs[11] = mk(rq(1'b1, OP_SRL, 32'h8000_0000, '0, '0, 1'b0, 5'd31, 1'b1), idle0,
                  1'b1, 1'b0, 1'b1, 32'h1, 1'b1, 32'h0);
    vecs[12] = mk(rq(1'b1, OP_ADD | OP_SUB, 32'd6, 32'd2, '0, 1'b0, '0, 1'b1), idle0,
                  1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'h0);

    // Reset held with r0 requesting: no ready, ALU outputs idle, slots empty.
    reset = 1'b1;
    drive(rq(1'b1, OP_XOR, 32'h3, 32'h5, '0, 1'b0, '0, 1'b0), idle0);
    #2;
    chk("reset_ready0", {31'b0, r0_if.ready}, 32'h0);
    chk("reset_alu_op", {22'b0, alu_op}, 32'h0);
    chk("reset_alu_rs1", alu_rs1, 32'h0);
    chk("reset_rvalid0", {31'b0, r0_if.rvalid}, 32'h0);
    chk("reset_rvalid1", {31'b0, r1_if.rvalid}, 32'h0);
    chk("reset_res0", r0_if.res, 32'h0);
    chk("reset_res1", r1_if.res, 32'h0);
    @(negedge clock);
    drive(idle0, idle0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      drive(vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("v%0d_ready0", i), {31'b0, r0_if.ready}, {31'b0, vecs[i].ready0});
      chk($sformatf("v%0d_ready1", i), {31'b0, r1_if.ready}, {31'b0, vecs[i].ready1});
      chk($sformatf("v%0d_alu_op", i), {22'b0, alu_op},
          {22'b0, vecs[i].ready0 ? vecs[i].r0.op : (vecs[i].ready1 ? vecs[i].r1.op : 10'b0)});
      chk($sformatf("v%0d_alu_rs1", i), alu_rs1,
          vecs[i].ready0 ? vecs[i].r0.rs1 : (vecs[i].ready1 ? vecs[i].r1.rs1 : 32'h0));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rvalid0", i), {31'b0, r0_if.rvalid}, {31'b0, vecs[i].rv0});
      chk($sformatf("v%0d_res0", i), r0_if.res, vecs[i].res0);
      chk($sformatf("v%0d_rvalid1", i), {31'b0, r1_if.rvalid}, {31'b0, vecs[i].rv1});
      chk($sformatf("v%0d_res1", i), r1_if.res, vecs[i].res1);
      $display("vec %0d: ready=%0b%0b rvalid=%0b%0b res0=0x%08h res1=0x%08h",
               i, r1_if.ready, r0_if.ready, r1_if.rvalid, r0_if.rvalid, r0_if.res, r1_if.res);
    end

    // Asynchronous reset mid-cycle with both slots full and r1 waiting.
    @(negedge clock);
    drive(idle0, rq(1'b1, OP_XOR, 32'h1, 32'h3, '0, 1'b0, '0, 1'b0));
    #1;
    chk("pre_rst_ready1", {31'b0, r1_if.ready}, 32'h0);
    chk("pre_rst_rvalid0", {31'b0, r0_if.rvalid}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rvalid0", {31'b0, r0_if.rvalid}, 32'h0);
    chk("async_res0", r0_if.res, 32'h0);
    chk("async_rvalid1", {31'b0, r1_if.rvalid}, 32'h0);
    chk("async_ready1", {31'b0, r1_if.ready}, 32'h0);
    chk("async_alu_op", {22'b0, alu_op}, 32'h0);
    $display("async reset: rvalid=%0b%0b ready=%0b%0b", r1_if.rvalid, r0_if.rvalid,
             r1_if.ready, r0_if.ready);

    @(negedge clock);
    reset = 1'b0;
    drive(rq(1'b1, OP_XOR, 32'hF0, 32'hFF, '0, 1'b0, '0, 1'b0),
          rq(1'b1, OP_ADD, 32'h1, 32'h3, '0, 1'b0, '0, 1'b0));
    #1;
    chk("post_rst_ready0", {31'b0, r0_if.ready}, 32'h1);
    chk("post_rst_ready1", {31'b0, r1_if.ready}, 32'h0);
    @(posedge clock);
    #1;
    chk("post_rst_res0", r0_if.res, 32'h0F);
    chk("post_rst_rvalid1", {31'b0, r1_if.rvalid}, 32'h0);
    $display("post reset grant 0: res0=0x%08h", r0_if.res);
    @(negedge clock);
    drive(rq(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b1),
          rq(1'b1, OP_ADD, 32'h1, 32'h3, '0, 1'b0, '0, 1'b0));
    #1;
    chk("post_rst2_ready1", {31'b0, r1_if.ready}, 32'h1);
    @(posedge clock);
    #1;
    chk("post_rst2_res1", r1_if.res, 32'h4);
    chk("post_rst2_rvalid0", {31'b0, r0_if.rvalid}, 32'h0);
    $display("post reset grant 1: res1=0x%08h", r1_if.res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational integer ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/CSR helper path.
- Arbitration is round-robin, with a valid/ready request handshake on each requester.
- Each requester has a one-entry registered response slot with its own valid/ready handshake.
- The block sits between the requesters and the ALU. It drives the ALU operand and opcode fields and captures the ALU result.

Parameters:
- XLEN, 32, datapath width.
- OPW, 10, width of the opcode vector. Bit order: 0 add, 1 sub, 2 sll, 3 srl, 4 sra, 5 slt, 6 sltu, 7 and, 8 or, 9 xor.
- FIRST, 0, requester that holds priority after reset (0 or 1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rN_valid  in  1  requester N (N=0,1) presents an operation.
- rN_ready  out  1  requester N operation accepted this cycle.
- rN_op  in  OPW  opcode vector.
- rN_rs1  in  XLEN  operand 1.
- rN_rs2  in  XLEN  operand 2.
- rN_imm  in  XLEN  immediate.
- rN_sel  in  1  selects imm (1) or rs2 (0) as operand 2.
- rN_shamt  in  5  shift amount.
- rN_rvalid  out  1  response slot N holds a result.
- rN_rready  in  1  requester N consumes the response.
- rN_res  out  XLEN  result held in response slot N.
- alu_op  out  OPW  opcode to the ALU.
- alu_rs1  out  XLEN  operand 1 to the ALU.
- alu_rs2  out  XLEN  operand 2 to the ALU.
- alu_imm  out  XLEN  immediate to the ALU.
- alu_sel  out  1  operand-2 select to the ALU.
- alu_shamt  out  5  shift amount to the ALU.
- alu_res  in  XLEN  combinational result from the ALU.

Behaviour:
- Reset (asynchronous, any time, including with a request or response pending):
  - rN_rvalid=0, rN_res=0.
  - Priority pointer = FIRST.
  - Pending responses are discarded.
  - While reset is high, rN_ready=0 and all alu_* outputs are 0.
- Slot availability: slot N is free when rN_rvalid=0, or when rN_rvalid=1 and rN_rready=1 in the same cycle (pass-through drain).
- Eligibility: requester N is eligible when rN_valid=1 and slot N is free.
- Grant, combinational, at most one grant per cycle:
  - Only one requester eligible: that requester is granted.
  - Both eligible: the requester named by the priority pointer is granted.
  - Neither eligible: no grant.
- Handshake: rN_ready=1 only for the granted requester. A request is accepted when rN_valid and rN_ready are both 1.
- ALU outputs: alu_* carry the granted requester's fields. With no grant they are all 0 (opcode 0, so the ALU outputs 0).
- Capture on an accepted grant:
  - At the rising edge, rN_res <= alu_res and rN_rvalid <= 1.
  - Latency from acceptance to rN_rvalid is 1 cycle.
- Response retirement:
  - rN_rvalid=1 and rN_rready=1 with no new grant to N: rN_rvalid <= 0 and rN_res holds its value.
  - Drain and grant to N in the same cycle: the new result overwrites the slot and rN_rvalid stays 1.
- Priority pointer:
  - After any accepted grant, the pointer moves to the other requester.
  - With no grant, the pointer is unchanged.
  - This guarantees a waiting eligible requester is granted within 2 cycles.
- Requester protocol: fields must stay stable while rN_valid=1 and rN_ready=0. The block does not latch requests. A requester may drop rN_valid before acceptance without side effects.
- Response protocol: rN_res is stable while rN_rvalid=1 and it has not been consumed.
- Slot full without drain: requester N is ineligible. The other requester may still be granted that cycle (no head-of-line blocking across requesters).
- Opcode handling: the block passes the opcode vector unmodified, including multi-bit codes such as add+sub. No opcode is decoded except that the all-zero opcode is still a valid request and returns the ALU output (0).
- Widths: all data paths are XLEN and no arithmetic is done in the block.

Test Plan:
- Single requester: r0 xor rs1=0x0000_00F0, rs2=0x0000_00FF, sel=0 → r0_ready=1 in cycle 0, r0_rvalid=1 and r0_res=0x0000_000F in cycle 1.
- Simultaneous requests after reset, FIRST=0: r0 and=0xFF00&0x0FF0, r1 sll rs1=1 shamt=4 →
  - cycle 0: r0 granted, r0_res=0x0F00.
  - cycle 1: r1 granted, r1_res=0x10.
  - pointer returns to r0.
- Backpressure:
  - r0_rready=0 with r0_rvalid=1: a new r0 request sees r0_ready=0 for 3 cycles while r1 requests are granted each cycle.
  - Raising r0_rready: the pending r0 request is granted in that same cycle and r0_rvalid stays 1 with the new result.
- Drain only: r1_rvalid=1, r1_rready=1, r1_valid=0 → next cycle r1_rvalid=0 and r1_res unchanged.
- Immediate select: r1 or, rs1=0x1, imm=0x8, sel=1, rs2=0xFFFF_FFFF → r1_res=0x9.
- Reset mid-operation: assert reset asynchronously while r0_rvalid=1 and r1 is waiting → outputs clear before the next clock edge. After release, a simultaneous r0/r1 request grants r0 first (FIRST=0).
